pyc_fifo_ex: RTL and testbench
==============================

# pyc_fifo_ex

Parametrised ready/valid FIFO, the successor to the basic prototype FIFO. It adds:
- arbitrary (non-power-of-two) depth;
- optional zero-latency bypass when empty;
- a synchronous flush;
- occupancy output with programmable almost-full/almost-empty flags.

It sits between pipeline stages and at block boundaries wherever back-pressure absorption and occupancy visibility are needed.

## Interface
Parameters:
- WIDTH, 1, data width in bits (≥1)
- DEPTH, 2, number of entries (≥1, any integer)
- AF_LEVEL, DEPTH-1, almost_full asserts when count ≥ AF_LEVEL (0..DEPTH)
- AE_LEVEL, 1, almost_empty asserts when count ≤ AE_LEVEL (0..DEPTH)
- BYPASS, 0, 1 = empty FIFO forwards in_data to out_data combinationally

Ports:
- clk  in  1  clock, all state on rising edge
- rst  in  1  reset, asynchronous, active-high
- flush  in  1  synchronous clear of all contents
- in_valid  in  1  producer has data
- in_ready  out  1  FIFO accepts data this cycle
- in_data  in  WIDTH  producer data
- out_valid  out  1  FIFO presents data
- out_ready  in  1  consumer accepts data
- out_data  out  WIDTH  head data
- count  out  $clog2(DEPTH+1)  current stored entries (bypassed words never counted)
- almost_full  out  1  count ≥ AF_LEVEL
- almost_empty  out  1  count ≤ AE_LEVEL

## Operation
- One clock, clk. Reset is asynchronous, active-high, on rst. Asserting rst immediately clears rd_ptr, wr_ptr and count to 0.
- Output values at reset:
  - in_ready=1, out_valid=0, count=0.
  - almost_empty=1.
  - almost_full=(AF_LEVEL==0).
  - out_data is don't-care; the storage array is not reset.
- Handshake rules:
  - push = in_valid && in_ready.
  - pop = out_valid && out_ready.
  - in_valid and in_data must remain stable until accepted; out side likewise.
- out_valid:
  - out_valid = (count != 0), or, when BYPASS=1, (count==0 && in_valid && !flush).
- in_ready:
  - in_ready = !flush && (count < DEPTH || pop).
  - When full, a simultaneous pop permits a push in the same cycle.
- Bypass (BYPASS=1, count==0):
  - out_data = in_data.
  - If out_ready, the word passes through; no storage write occurs and count is unchanged.
  - If !out_ready, the word is stored normally.
- Pointers:
  - rd_ptr and wr_ptr wrap from DEPTH-1 to 0. This must be correct for non-power-of-two DEPTH.
  - With DEPTH=1, both pointers stay at 0.
- count update per cycle: +1 on a non-bypassed push without pop, −1 on pop without push, unchanged on push+pop or on neither.
- Flush:
  - Highest priority below rst.
  - While flush=1: in_ready=0, out_valid=0, no transfer occurs, and the next edge sets pointers and count to 0.
- Flags are combinational functions of registered count; they reflect the new count the cycle after an update.
- Illegal parameter values (DEPTH<1, AF_LEVEL or AE_LEVEL outside 0..DEPTH) cause $fatal at elaboration.

## Timing
- Latency, BYPASS=0: a pushed word is visible on out_valid/out_data at the cycle after the push edge.
- Latency, BYPASS=1: zero cycles when the FIFO is empty; otherwise one cycle.
- Combinational paths:
  - out_ready → in_ready (always).
  - in_valid/in_data → out_valid/out_data (BYPASS=1 only).
  - Integrators must not close a loop through these paths.
- Throughput: one push and one pop per cycle sustained at any occupancy, including full and empty (bypass case).
- A rst edge mid-transfer discards the transfer. The first legal push is in the cycle after rst deasserts.

## Structure
- Package pyc_fifo_pkg:
  - function ptr_w(depth), returning max(1, $clog2(depth));
  - function cnt_w(depth), returning $clog2(depth+1);
  - shared by this block and future FIFO variants.
- Sub-module pyc_wrap_ctr:
  - parameter MOD;
  - increments on en, wraps MOD-1 → 0, with synchronous clear and asynchronous reset;
  - instantiated twice, for the read and write pointers.
- Storage is a plain register array written on push, read asynchronously at rd_ptr.

## Test plan
- Reset/fill/drain, DEPTH=3, WIDTH=8:
  - Stimulus: push 0x11,0x22,0x33 with out_ready=0, then drain.
  - Required: count 1,2,3; in_ready=0 at count=3; almost_full=1 at 2.
  - Required: drain yields 0x11,0x22,0x33 in order, then out_valid=0 and almost_empty=1.
- Full push+pop, DEPTH=3:
  - Stimulus: when full, in_valid=1 and out_ready=1 for 4 cycles.
  - Required: in_ready=1, count stays 3, FIFO order preserved.
  - Required: pointer wrap 2→0 is exercised without data loss.
- Bypass, BYPASS=1:
  - Stimulus: empty FIFO, in_valid=1, in_data=0xAB, out_ready=1.
  - Required: out_valid=1 and out_data=0xAB in the same cycle; count stays 0.
  - Stimulus: the same with out_ready=0.
  - Required: count=1 at the next cycle.
- Flush with count=2, in_valid=1:
  - Required: in_ready=0 and out_valid=0 during flush.
  - Required: the next cycle shows count=0, and the held word is not stored.
- Async reset:
  - Stimulus: assert rst between clock edges with count=2.
  - Required: count=0 and out_valid=0 before the next edge; FIFO refills normally after release.
- DEPTH=1 randomised:
  - Stimulus: 1000 cycles of random valid/ready against a scoreboard.
  - Required: no loss, no duplication, and count ≤ 1 throughout.

Source files
------------

// File: rtl/pyc_fifo_pkg.sv
// Shared sizing helpers for the pyc FIFO family.
package pyc_fifo_pkg;

    // Pointer width: never narrower than one bit, even for a single-entry FIFO.
    function automatic int ptr_w(input int depth);
        int w;
        w = $clog2(depth);
        return (w < 1) ? 1 : w;
    endfunction

    // Occupancy width: must represent 0..depth inclusive.
    function automatic int cnt_w(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/pyc_wrap_ctr.sv
// Modulo-MOD up-counter used as a FIFO read/write pointer.
module pyc_wrap_ctr
    import pyc_fifo_pkg::*;
#(
    parameter int MOD = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clr,
    input  logic                  en,
    output logic [ptr_w(MOD)-1:0] value
);

    localparam int W = ptr_w(MOD);
    localparam logic [W-1:0] LAST = W'(MOD - 1);

    // Advance on en, wrapping explicitly so non-power-of-two MOD works.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            value <= '0;
        end else if (clr) begin
            value <= '0;
        end else if (en) begin
            value <= (value == LAST) ? '0 : value + W'(1);
        end
    end

endmodule

// File: rtl/pyc_fifo_ex.sv
// Ready/valid FIFO with arbitrary depth, optional empty bypass, flush and
// occupancy flags.
module pyc_fifo_ex
    import pyc_fifo_pkg::*;
#(
    parameter int WIDTH    = 1,
    parameter int DEPTH    = 2,
    parameter int AF_LEVEL = DEPTH - 1,
    parameter int AE_LEVEL = 1,
    parameter int BYPASS   = 0
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         flush,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [WIDTH-1:0]             in_data,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [WIDTH-1:0]             out_data,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output logic                         almost_full,
    output logic                         almost_empty
);

    localparam int PW = ptr_w(DEPTH);
    localparam int CW = cnt_w(DEPTH);
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
    localparam logic [CW-1:0] AF_C    = CW'(AF_LEVEL);
    localparam logic [CW-1:0] AE_C    = CW'(AE_LEVEL);
    localparam logic          BYP     = (BYPASS != 0);

    if (DEPTH < 1) begin : g_bad_depth
        $fatal(1, "pyc_fifo_ex: DEPTH must be >= 1");
    end
    if (AF_LEVEL < 0 || AF_LEVEL > DEPTH) begin : g_bad_af
        $fatal(1, "pyc_fifo_ex: AF_LEVEL must be in 0..DEPTH");
    end
    if (AE_LEVEL < 0 || AE_LEVEL > DEPTH) begin : g_bad_ae
        $fatal(1, "pyc_fifo_ex: AE_LEVEL must be in 0..DEPTH");
    end

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    rd_ptr;
    logic [PW-1:0]    wr_ptr;
    logic             empty;
    logic             push;
    logic             pop;
    logic             pass_through;
    logic             wr_en;
    logic             rd_en;

    // Handshake decode; a word that enters and leaves an empty bypass FIFO in
    // the same cycle touches neither storage nor the pointers.
    always_comb begin
        empty        = (count == '0);
        out_valid    = !flush && (!empty || (BYP && in_valid));
        pop          = out_valid && out_ready;
        in_ready     = !flush && ((count < DEPTH_C) || pop);
        push         = in_valid && in_ready;
        pass_through = BYP && empty && push && pop;
        wr_en        = push && !pass_through;
        rd_en        = pop && !pass_through;
        out_data     = (BYP && empty) ? in_data : mem[rd_ptr];
        almost_full  = (count >= AF_C);
        almost_empty = (count <= AE_C);
    end

    // Storage array, written at the tail on each stored push; not reset.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr] <= in_data;
        end
    end

    // Occupancy tracking; flush empties the FIFO on the next edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (flush) begin
            count <= '0;
        end else if (wr_en && !rd_en) begin
            count <= count + CW'(1);
        end else if (rd_en && !wr_en) begin
            count <= count - CW'(1);
        end
    end

    pyc_wrap_ctr #(.MOD(DEPTH)) u_rd_ptr (
        .clk   (clk),
        .rst   (rst),
        .clr   (flush),
        .en    (rd_en),
        .value (rd_ptr)
    );

    pyc_wrap_ctr #(.MOD(DEPTH)) u_wr_ptr (
        .clk   (clk),
        .rst   (rst),
        .clr   (flush),
        .en    (wr_en),
        .value (wr_ptr)
    );

endmodule

// File: tb/tb_pyc_fifo_ex.sv
// Bench for pyc_fifo_ex: three instances (DEPTH=3 plain, DEPTH=3 bypass,
// DEPTH=1 plain) checked every cycle against a queue-based model, plus
// hand-computed expectations for the directed scenarios.
module tb_pyc_fifo_ex;

    logic       clk = 1'b0;
    logic       rst;
    logic       iv   [3];
    logic       fl   [3];
    logic       ordy [3];
    logic [7:0] idat [3];
    logic       ir   [3];
    logic       ov   [3];
    logic       afl  [3];
    logic       aef  [3];
    logic [7:0] od   [3];
    logic [1:0] cnt0;
    logic [1:0] cnt1;
    logic [0:0] cnt2;

    int n_checks = 0;
    int n_fail   = 0;

    // model configuration per instance
    int md  [3] = '{3, 3, 1};
    int mb  [3] = '{0, 1, 0};
    int maf [3] = '{2, 2, 0};
    int mae [3] = '{1, 1, 1};

    logic [7:0] mq [3][$];
    logic       m_push [3];

    always #5 clk = ~clk;

    pyc_fifo_ex #(.WIDTH(8), .DEPTH(3), .BYPASS(0)) u_d3 (
        .clk(clk), .rst(rst), .flush(fl[0]), .in_valid(iv[0]), .in_ready(ir[0]),
        .in_data(idat[0]), .out_valid(ov[0]), .out_ready(ordy[0]), .out_data(od[0]),
        .count(cnt0), .almost_full(afl[0]), .almost_empty(aef[0])
    );

    pyc_fifo_ex #(.WIDTH(8), .DEPTH(3), .BYPASS(1)) u_byp (
        .clk(clk), .rst(rst), .flush(fl[1]), .in_valid(iv[1]), .in_ready(ir[1]),
        .in_data(idat[1]), .out_valid(ov[1]), .out_ready(ordy[1]), .out_data(od[1]),
        .count(cnt1), .almost_full(afl[1]), .almost_empty(aef[1])
    );

    pyc_fifo_ex #(.WIDTH(8), .DEPTH(1), .BYPASS(0)) u_d1 (
        .clk(clk), .rst(rst), .flush(fl[2]), .in_valid(iv[2]), .in_ready(ir[2]),
        .in_data(idat[2]), .out_valid(ov[2]), .out_ready(ordy[2]), .out_data(od[2]),
        .count(cnt2), .almost_full(afl[2]), .almost_empty(aef[2])
    );

    task automatic chk(input string nm, input int k, input logic [31:0] act,
                       input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s[%0d] at %0t: got %0h expected %0h", nm, k, $time, act, exp);
        end
    endtask

    function automatic int dut_count(input int k);
        if (k == 0) return int'(cnt0);
        if (k == 1) return int'(cnt1);
        return int'(cnt2);
    endfunction

    // Per-cycle model compare: outputs are sampled on the falling edge, then
    // the model applies the transfer that the next rising edge will commit.
    always @(negedge clk) begin
        int n;
        logic e_ov, e_ir, p_pop, p_push;
        logic [7:0] e_od;
        for (int k = 0; k < 3; k++) begin
            if (rst) begin
                chk("rst_in_ready", k, 32'(ir[k]), 32'd1);
                chk("rst_out_valid", k, 32'(ov[k]), 32'd0);
                chk("rst_count", k, dut_count(k), 32'd0);
                chk("rst_almost_empty", k, 32'(aef[k]), 32'd1);
                chk("rst_almost_full", k, 32'(afl[k]), 32'(maf[k] == 0));
                mq[k].delete();
                m_push[k] = 1'b0;
            end else begin
                n      = mq[k].size();
                e_ov   = !fl[k] && (n > 0 || (mb[k] != 0 && iv[k]));
                e_od   = (n > 0) ? mq[k][0] : idat[k];
                p_pop  = e_ov && ordy[k];
                e_ir   = !fl[k] && (n < md[k] || p_pop);
                p_push = iv[k] && e_ir;
                chk("out_valid", k, 32'(ov[k]), 32'(e_ov));
                chk("in_ready", k, 32'(ir[k]), 32'(e_ir));
                chk("count", k, dut_count(k), n);
                chk("almost_full", k, 32'(afl[k]), 32'(n >= maf[k]));
                chk("almost_empty", k, 32'(aef[k]), 32'(n <= mae[k]));
                if (e_ov) chk("out_data", k, 32'(od[k]), 32'(e_od));
                if (k == 2) chk("d1_count_le1", k, 32'(dut_count(k) <= 1), 32'd1);
                m_push[k] = p_push;
                if (fl[k]) begin
                    mq[k].delete();
                end else begin
                    if (p_pop && n > 0) void'(mq[k].pop_front());
                    if (p_push && !(n == 0 && p_pop)) mq[k].push_back(idat[k]);
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic look();
        @(negedge clk);
        #1;
    endtask

    task automatic drv(input int k, input logic v, input logic [7:0] d,
                       input logic r, input logic f);
        iv[k]   = v;
        idat[k] = d;
        ordy[k] = r;
        fl[k]   = f;
    endtask

    logic [7:0] pp_in  [4] = '{8'h44, 8'h55, 8'h66, 8'h77};
    logic [7:0] pp_out [4] = '{8'h81, 8'h82, 8'h83, 8'h44};
    logic [7:0] tail   [3] = '{8'h55, 8'h66, 8'h77};

    initial begin
        rst = 1'b1;
        for (int k = 0; k < 3; k++) drv(k, 1'b0, 8'h00, 1'b0, 1'b0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        // fill DEPTH=3 with out_ready low
        drv(0, 1'b1, 8'h11, 1'b0, 1'b0); step();
        drv(0, 1'b1, 8'h22, 1'b0, 1'b0); look();
        chk("fill_count1", 0, cnt0, 1);
        step();
        drv(0, 1'b1, 8'h33, 1'b0, 1'b0); look();
        chk("fill_count2", 0, cnt0, 2);
        chk("fill_af_at2", 0, afl[0], 1);
        step();
        drv(0, 1'b0, 8'h00, 1'b0, 1'b0); look();
        chk("fill_count3", 0, cnt0, 3);
        chk("full_in_ready", 0, ir[0], 0);
        step();

        // drain in order
        drv(0, 1'b0, 8'h00, 1'b1, 1'b0); look();
        chk("drain0", 0, od[0], 8'h11);
        step(); look();
        chk("drain1", 0, od[0], 8'h22);
        step(); look();
        chk("drain2", 0, od[0], 8'h33);
        step(); look();
        chk("drained_valid", 0, ov[0], 0);
        chk("drained_ae", 0, aef[0], 1);
        step();

        // full with simultaneous push and pop, crossing the 2->0 wrap
        drv(0, 1'b1, 8'h81, 1'b0, 1'b0); step();
        drv(0, 1'b1, 8'h82, 1'b0, 1'b0); step();
        drv(0, 1'b1, 8'h83, 1'b0, 1'b0); step();
        for (int i = 0; i < 4; i++) begin
            drv(0, 1'b1, pp_in[i], 1'b1, 1'b0); look();
            chk("pp_in_ready", 0, ir[0], 1);
            chk("pp_count", 0, cnt0, 3);
            chk("pp_out", 0, od[0], pp_out[i]);
            step();
        end
        drv(0, 1'b0, 8'h00, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) begin
            look();
            chk("pp_tail", 0, od[0], tail[i]);
            step();
        end
        drv(0, 1'b0, 8'h00, 1'b0, 1'b0);

        // flush with two stored words and a pending push
        drv(0, 1'b1, 8'hA1, 1'b0, 1'b0); step();
        drv(0, 1'b1, 8'hA2, 1'b0, 1'b0); step();
        drv(0, 1'b1, 8'h99, 1'b0, 1'b1); look();
        chk("flush_in_ready", 0, ir[0], 0);
        chk("flush_out_valid", 0, ov[0], 0);
        step();
        drv(0, 1'b0, 8'h00, 1'b0, 1'b0); look();
        chk("post_flush_count", 0, cnt0, 0);
        step();
        drv(0, 1'b1, 8'hB1, 1'b0, 1'b0); step();
        drv(0, 1'b0, 8'h00, 1'b0, 1'b0); look();
        chk("post_flush_head", 0, od[0], 8'hB1);
        step();
        drv(0, 1'b0, 8'h00, 1'b1, 1'b0); step();
        drv(0, 1'b0, 8'h00, 1'b0, 1'b0);

        // bypass instance: pass-through, then stored when consumer stalls
        drv(1, 1'b1, 8'hAB, 1'b1, 1'b0); look();
        chk("byp_valid", 1, ov[1], 1);
        chk("byp_data", 1, od[1], 8'hAB);
        chk("byp_count", 1, cnt1, 0);
        step();
        drv(1, 1'b1, 8'hCD, 1'b0, 1'b0); look();
        chk("byp_stall_data", 1, od[1], 8'hCD);
        step();
        drv(1, 1'b0, 8'h00, 1'b0, 1'b0); look();
        chk("byp_stored_count", 1, cnt1, 1);
        chk("byp_stored_data", 1, od[1], 8'hCD);
        step();
        drv(1, 1'b0, 8'h00, 1'b1, 1'b0); step();
        drv(1, 1'b0, 8'h00, 1'b0, 1'b0);

        // asynchronous reset between edges with two words stored
        drv(0, 1'b1, 8'hC1, 1'b0, 1'b0); step();
        drv(0, 1'b1, 8'hC2, 1'b0, 1'b0); step();
        drv(0, 1'b0, 8'h00, 1'b0, 1'b0); look();
        chk("pre_rst_count", 0, cnt0, 2);
        @(posedge clk);
        #3 rst = 1'b1;
        #1;
        chk("async_rst_count", 0, cnt0, 0);
        chk("async_rst_valid", 0, ov[0], 0);
        @(posedge clk);
        #1 rst = 1'b0;
        drv(0, 1'b1, 8'hD1, 1'b0, 1'b0); step();
        drv(0, 1'b0, 8'h00, 1'b0, 1'b0); look();
        chk("refill_count", 0, cnt0, 1);
        chk("refill_data", 0, od[0], 8'hD1);
        step();
        drv(0, 1'b0, 8'h00, 1'b1, 1'b0); step();

        // randomised traffic on all instances, holding unaccepted words
        for (int c = 0; c < 1000; c++) begin
            for (int k = 0; k < 3; k++) begin
                if (!(iv[k] && !m_push[k])) begin
                    iv[k]   = 1'($urandom_range(0, 1));
                    idat[k] = 8'($urandom);
                end
                ordy[k] = 1'($urandom_range(0, 1));
                fl[k]   = ($urandom_range(0, 31) == 0);
            end
            step();
        end
        for (int k = 0; k < 3; k++) drv(k, 1'b0, 8'h00, 1'b1, 1'b0);
        repeat (4) step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
